// File: rtl/time_ctrl_pkg.sv
// Shared types and constants for the sweep-time controller.
// One-hot state encoding keeps the per-state decode down to single-bit tests.
package time_ctrl_pkg;

  typedef enum logic [5:0] {
    INIT_ST = 6'b000001,
    SYNC_ST = 6'b000010,
    CNT_ST  = 6'b000100,
    WAIT_ST = 6'b001000,
    LOOP_ST = 6'b010000,
    END_ST  = 6'b100000
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_NLOOP  = 2'd1;
  localparam logic [1:0] MODE_CONT   = 2'd2;

endpackage

// File: rtl/time_ctrl_hold_cnt.sv
// Per-sample hold counter: loaded with the hold length, counts down while enabled,
// and flags the final hold cycle so the sequencer can leave WAIT on time.
module time_ctrl_hold_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - ONE_W;
    end
  end

  assign tc_o = (cnt_q == ONE_W);

endmodule

// File: rtl/time_ctrl_seq.sv
// Sweep-time generator: emits a sync pulse and a time index 0..max by step with
// optional per-sample hold, repeating per mode; all outputs are registered.
module time_ctrl_seq
  import time_ctrl_pkg::*;
#(
  parameter int B = 16,
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  output logic         busy,
  output logic         sync,
  output logic         valid,
  output logic         last,
  output logic         done,
  output logic [B-1:0] t_out,
  output logic [N-1:0] loop_out,
  input  logic [B-1:0] CNT_MAX_REG,
  input  logic [B-1:0] STEP_REG,
  input  logic [W-1:0] WAIT_REG,
  input  logic [N-1:0] NLOOP_REG,
  input  logic [1:0]   MODE_REG
);

  localparam logic [B-1:0] ONE_B = {{(B-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q;
  logic [B-1:0] cnt_q;
  logic [N-1:0] loop_q;
  logic [B-1:0] max_q;
  logic [B-1:0] step_q;
  logic [W-1:0] wait_q;
  logic [N-1:0] nloop_q;
  logic [1:0]   mode_q;
  logic         fin_q;

  logic         busy_q, sync_pipe_q, sync_q, valid_q, last_q, done_q;
  logic [B-1:0] t_q;
  logic [N-1:0] loop_out_q;

  logic         init_st, sync_st, cnt_st, wait_st, loop_st, end_st;
  logic [B:0]   cnt_inc_d;
  logic         sweep_end;
  logic         loop_over;
  logic         hold_load, hold_tc;

  assign init_st = (state_q == INIT_ST);
  assign sync_st = (state_q == SYNC_ST);
  assign cnt_st  = (state_q == CNT_ST);
  assign wait_st = (state_q == WAIT_ST);
  assign loop_st = (state_q == LOOP_ST);
  assign end_st  = (state_q == END_ST);

  // The extra carry bit lets a sweep end cleanly at CNT_MAX = 2^B-1 without wrapping.
  assign cnt_inc_d = {1'b0, cnt_q} + {1'b0, step_q};
  assign sweep_end = (cnt_q == max_q) || (cnt_inc_d > {1'b0, max_q});

  always_comb begin
    loop_over = 1'b1;
    case (mode_q)
      MODE_NLOOP: loop_over = (loop_q == (nloop_q - ONE_N));
      MODE_CONT:  loop_over = !start;
      default:    loop_over = 1'b1;
    endcase
  end

  assign hold_load = cnt_st && (wait_q != '0) && !stop;

  time_ctrl_hold_cnt #(.W(W)) u_hold (
    .clk        (clk),
    .rst_i      (rst),
    .load_i     (hold_load),
    .load_val_i (wait_q),
    .en_i       (wait_st),
    .tc_o       (hold_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT_ST;
      cnt_q       <= '0;
      loop_q      <= '0;
      max_q       <= '0;
      step_q      <= '0;
      wait_q      <= '0;
      nloop_q     <= '0;
      mode_q      <= '0;
      fin_q       <= 1'b0;
      busy_q      <= 1'b0;
      sync_pipe_q <= 1'b0;
      sync_q      <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      t_q         <= '0;
      loop_out_q  <= '0;
    end else begin
      busy_q      <= sync_st || cnt_st || wait_st || loop_st;
      valid_q     <= cnt_st || wait_st;
      loop_out_q  <= loop_q;
      // Two-stage sync so the pulse lands on the first sample of the sweep.
      sync_pipe_q <= sync_st && !stop;
      sync_q      <= sync_pipe_q;
      done_q      <= 1'b0;

      if (cnt_st) begin
        t_q    <= cnt_q;
        last_q <= sweep_end;
      end else if (!wait_st) begin
        last_q <= 1'b0;
      end

      case (state_q)
        INIT_ST: begin
          if (start) begin
            max_q   <= CNT_MAX_REG;
            step_q  <= (STEP_REG == '0) ? ONE_B : STEP_REG;
            wait_q  <= WAIT_REG;
            nloop_q <= (NLOOP_REG == '0) ? ONE_N : NLOOP_REG;
            mode_q  <= MODE_REG;
            cnt_q   <= '0;
            loop_q  <= '0;
            state_q <= SYNC_ST;
          end
        end
        SYNC_ST: state_q <= stop ? END_ST : CNT_ST;
        CNT_ST: begin
          if (stop) begin
            state_q <= END_ST;
          end else if (wait_q != '0) begin
            // The final sample also gets its hold; remember to leave WAIT for LOOP.
            fin_q   <= sweep_end;
            state_q <= WAIT_ST;
            if (!sweep_end) cnt_q <= cnt_inc_d[B-1:0];
          end else if (sweep_end) begin
            state_q <= LOOP_ST;
          end else begin
            cnt_q <= cnt_inc_d[B-1:0];
          end
        end
        WAIT_ST: begin
          if (stop) begin
            state_q <= END_ST;
          end else if (hold_tc) begin
            state_q <= fin_q ? LOOP_ST : CNT_ST;
          end
        end
        LOOP_ST: begin
          if (stop) begin
            state_q <= END_ST;
          end else if (loop_over) begin
            state_q <= END_ST;
            done_q  <= 1'b1;
          end else begin
            loop_q  <= loop_q + ONE_N;
            cnt_q   <= '0;
            state_q <= SYNC_ST;
          end
        end
        END_ST: if (!start) state_q <= INIT_ST;
        default: state_q <= INIT_ST;
      endcase
    end
  end

  assign busy     = busy_q;
  assign sync     = sync_q;
  assign valid    = valid_q;
  assign last     = last_q;
  assign done     = done_q;
  assign t_out    = t_q;
  assign loop_out = loop_out_q;

endmodule

// File: tb/tb_time_ctrl_seq.sv
// Bench for time_ctrl_seq: a sweep/sample-level model builds the expected output
// trace of each scenario, which is then compared with the DUT on every cycle.
module tb_time_ctrl_seq;

  localparam int B   = 16;
  localparam int W   = 8;
  localparam int N   = 8;
  localparam int LEN = 220;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, stop;
  logic         busy, sync, valid, last, done;
  logic [B-1:0] t_out;
  logic [N-1:0] loop_out;
  logic [B-1:0] cnt_max, step_r;
  logic [W-1:0] wait_r;
  logic [N-1:0] nloop_r;
  logic [1:0]   mode_r;

  time_ctrl_seq #(.B(B), .W(W), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .busy        (busy),
    .sync        (sync),
    .valid       (valid),
    .last        (last),
    .done        (done),
    .t_out       (t_out),
    .loop_out    (loop_out),
    .CNT_MAX_REG (cnt_max),
    .STEP_REG    (step_r),
    .WAIT_REG    (wait_r),
    .NLOOP_REG   (nloop_r),
    .MODE_REG    (mode_r)
  );

  // per-cycle stimulus of one scenario
  bit           rst_w   [0:LEN-1];
  bit           start_w [0:LEN-1];
  bit           stop_w  [0:LEN-1];
  logic [B-1:0] max_w   [0:LEN-1];
  int           s_step, s_wait, s_nloop, s_mode;

  // expected and captured outputs, indexed by cycle
  bit e_busy[0:LEN-1], e_sync[0:LEN-1], e_valid[0:LEN-1], e_last[0:LEN-1], e_done[0:LEN-1];
  int e_t[0:LEN-1], e_lp[0:LEN-1];
  bit c_busy[0:LEN-1], c_sync[0:LEN-1], c_valid[0:LEN-1], c_last[0:LEN-1], c_done[0:LEN-1];
  int c_t[0:LEN-1], c_lp[0:LEN-1];

  int n_tests = 0;
  int n_fail  = 0;

  // model cursor: mx is the cycle whose behaviour is being decided
  int mx, cur_t, cur_lp;
  bit halt;

  // outputs seen in cycle mx+1 are the consequence of what happened in cycle mx
  function automatic void emit(bit b, bit v, bit l, bit d);
    if (mx + 1 < LEN) begin
      e_busy[mx+1]  = b;
      e_valid[mx+1] = v;
      e_last[mx+1]  = l;
      e_done[mx+1]  = d;
      e_t[mx+1]     = cur_t;
      e_lp[mx+1]    = cur_lp;
    end
    mx++;
    if (mx >= LEN - 3) halt = 1'b1;
  endfunction

  function automatic void emit_rst();
    cur_t  = 0;
    cur_lp = 0;
    if (mx + 1 < LEN) e_sync[mx+1] = 1'b0;
    if (mx + 2 < LEN) e_sync[mx+2] = 1'b0;
    emit(1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // One run from the SYNC cycle onward; returns with mx at the END cycle or, after
  // a reset, at the following INIT cycle.
  task automatic run_sweeps(output bit was_rst);
    int smax, st, nl, t;
    bit fin, over, sp;
    was_rst = 1'b0;
    smax    = int'(max_w[mx-1]);
    st      = (s_step == 0) ? 1 : s_step;
    nl      = (s_nloop == 0) ? 1 : s_nloop;
    cur_lp  = 0;
    for (int sw = 0; ; sw++) begin
      if (halt) return;
      if (rst_w[mx]) begin emit_rst(); was_rst = 1'b1; return; end
      sp = stop_w[mx];
      emit(1'b1, 1'b0, 1'b0, 1'b0);
      if (sp) return;
      if (mx + 1 < LEN) e_sync[mx+1] = 1'b1;
      t = 0;
      forever begin
        fin = (t == smax) || (t + st > smax);
        for (int h = 0; h <= s_wait; h++) begin
          if (halt) return;
          if (rst_w[mx]) begin emit_rst(); was_rst = 1'b1; return; end
          sp    = stop_w[mx];
          cur_t = t;
          emit(1'b1, 1'b1, fin, 1'b0);
          if (sp) return;
        end
        if (fin) break;
        t += st;
      end
      if (halt) return;
      if (rst_w[mx]) begin emit_rst(); was_rst = 1'b1; return; end
      sp   = stop_w[mx];
      over = (s_mode == 1) ? (sw == nl - 1) : (s_mode == 2) ? !start_w[mx] : 1'b1;
      emit(1'b1, 1'b0, 1'b0, over && !sp);
      if (sp || over) return;
      cur_lp = (sw + 1) & 255;
    end
  endtask

  task automatic build();
    bit r, s;
    for (int k = 0; k < LEN; k++) begin
      e_busy[k] = 0; e_sync[k] = 0; e_valid[k] = 0; e_last[k] = 0; e_done[k] = 0;
      e_t[k] = 0; e_lp[k] = 0;
    end
    mx = 0; cur_t = 0; cur_lp = 0; halt = 1'b0;
    while (!halt) begin
      if (rst_w[mx]) begin emit_rst(); continue; end
      s = start_w[mx];
      emit(1'b0, 1'b0, 1'b0, 1'b0);
      if (!s) continue;
      run_sweeps(r);
      if (r) continue;
      while (!halt) begin
        if (rst_w[mx]) begin emit_rst(); break; end
        s = start_w[mx];
        emit(1'b0, 1'b0, 1'b0, 1'b0);
        if (!s) break;
      end
    end
  endtask

  task automatic set_scn(int mxv, int stp, int wt, int nlp, int md, int st_on, int st_off);
    s_step = stp; s_wait = wt; s_nloop = nlp; s_mode = md;
    for (int c = 0; c < LEN; c++) begin
      rst_w[c]   = (c < 2);
      start_w[c] = (c >= st_on) && (c < st_off);
      stop_w[c]  = 1'b0;
      max_w[c]   = mxv[B-1:0];
    end
  endtask

  task automatic run_scn(string name);
    build();
    for (int c = 0; c < LEN - 2; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        c_busy[c] = busy; c_sync[c] = sync; c_valid[c] = valid; c_last[c] = last;
        c_done[c] = done; c_t[c] = int'(t_out); c_lp[c] = int'(loop_out);
        n_tests++;
        if (busy !== e_busy[c] || sync !== e_sync[c] || valid !== e_valid[c] ||
            last !== e_last[c] || done !== e_done[c] || int'(t_out) != e_t[c] ||
            int'(loop_out) != e_lp[c]) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got busy=%b sync=%b valid=%b last=%b done=%b t=%0d loop=%0d, want busy=%b sync=%b valid=%b last=%b done=%b t=%0d loop=%0d",
                   name, c, busy, sync, valid, last, done, t_out, loop_out,
                   e_busy[c], e_sync[c], e_valid[c], e_last[c], e_done[c], e_t[c], e_lp[c]);
        end
      end
      rst     = rst_w[c];
      start   = start_w[c];
      stop    = stop_w[c];
      cnt_max = max_w[c];
      step_r  = s_step[B-1:0];
      wait_r  = s_wait[W-1:0];
      nloop_r = s_nloop[N-1:0];
      mode_r  = s_mode[1:0];
    end
    $display("[TB] scenario %s: mode=%0d max=%0d step=%0d wait=%0d nloop=%0d", name,
             s_mode, max_w[2], s_step, s_wait, s_nloop);
  endtask

  function automatic int count_sig(int sig, bit from_dut);
    int n = 0;
    bit v;
    for (int k = 1; k < LEN - 2; k++) begin
      case (sig)
        0:       v = from_dut ? c_valid[k] : e_valid[k];
        1:       v = from_dut ? c_last[k]  : e_last[k];
        2:       v = from_dut ? c_sync[k]  : e_sync[k];
        default: v = from_dut ? c_done[k]  : e_done[k];
      endcase
      n += int'(v);
    end
    return n;
  endfunction

  function automatic int last_t(bit from_dut);
    int r = -1;
    for (int k = 1; k < LEN - 2; k++) begin
      if (from_dut ? (c_valid[k] && c_last[k]) : (e_valid[k] && e_last[k]))
        r = from_dut ? c_t[k] : e_t[k];
    end
    return r;
  endfunction

  task automatic lit(string nm, int dut_v, int mod_v, int want);
    n_tests += 2;
    if (mod_v != want) begin
      n_fail++;
      $display("FAIL %s (model): got %0d, want %0d", nm, mod_v, want);
    end
    if (dut_v != want) begin
      n_fail++;
      $display("FAIL %s (dut): got %0d, want %0d", nm, dut_v, want);
    end
  endtask

  task automatic rand_scn(int idx);
    int lvl, seg, c, mxv, stp, chg;
    if ($urandom_range(0, 5) == 0) begin
      mxv = $urandom_range(65530, 65535);
      stp = $urandom_range(16000, 40000);
    end else begin
      mxv = $urandom_range(0, 12);
      stp = $urandom_range(0, 4);
    end
    set_scn(mxv, stp, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), LEN, LEN);
    lvl = 0;
    c   = 2;
    while (c < LEN) begin
      seg = $urandom_range(3, 50);
      for (int k = 0; k < seg && c < LEN; k++) begin
        start_w[c] = lvl[0];
        c++;
      end
      lvl ^= 1;
    end
    for (int k = 2; k < LEN; k++) begin
      stop_w[k] = ($urandom_range(0, 49) == 0);
      rst_w[k]  = ($urandom_range(0, 119) == 0);
    end
    if ($urandom_range(0, 1) == 1) begin
      chg = $urandom_range(5, LEN - 1);
      mxv = $urandom_range(0, 12);
      for (int k = chg; k < LEN; k++) max_w[k] = mxv[B-1:0];
    end
    run_scn($sformatf("rand%0d", idx));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cnt_max = '0; step_r = '0; wait_r = '0; nloop_r = '0; mode_r = '0;

    // single sweep, start at cycle 4
    set_scn(7, 1, 0, 0, 0, 4, 60);
    run_scn("single_max7");
    lit("t1 reset busy@2", c_busy[2], e_busy[2], 0);
    lit("t1 valid@6", c_valid[6], e_valid[6], 0);
    lit("t1 sync@7", c_sync[7], e_sync[7], 1);
    lit("t1 valid@7", c_valid[7], e_valid[7], 1);
    lit("t1 last@14", c_last[14], e_last[14], 1);
    lit("t1 t@14", c_t[14], e_t[14], 7);
    lit("t1 done@15", c_done[15], e_done[15], 1);
    lit("t1 busy@16", c_busy[16], e_busy[16], 0);
    lit("t1 valid count", count_sig(0, 1), count_sig(0, 0), 8);

    set_scn(3, 1, 2, 0, 0, 4, 60);
    run_scn("hold2");
    lit("t2 valid count", count_sig(0, 1), count_sig(0, 0), 12);
    lit("t2 last count", count_sig(1, 1), count_sig(1, 0), 3);
    lit("t2 valid@18", c_valid[18], e_valid[18], 1);
    lit("t2 valid@19", c_valid[19], e_valid[19], 0);

    set_scn(10, 3, 0, 0, 0, 4, 60);
    run_scn("step3");
    lit("t3 valid count", count_sig(0, 1), count_sig(0, 0), 4);
    lit("t3 last t", last_t(1), last_t(0), 9);

    set_scn(3, 0, 0, 0, 0, 4, 60);
    run_scn("step0");
    lit("t3b valid count", count_sig(0, 1), count_sig(0, 0), 4);

    set_scn(2, 1, 0, 3, 1, 4, 100);
    run_scn("nloop3");
    lit("t4 sync count", count_sig(2, 1), count_sig(2, 0), 3);
    lit("t4 done count", count_sig(3, 1), count_sig(3, 0), 1);
    lit("t4 valid@10 gap", c_valid[10], e_valid[10], 0);
    lit("t4 valid@11 gap", c_valid[11], e_valid[11], 0);
    lit("t4 loop@12", c_lp[12], e_lp[12], 1);
    lit("t4 last loop", c_lp[19], e_lp[19], 2);

    set_scn(9, 1, 0, 0, 2, 4, 11);
    run_scn("cont_drop");
    lit("t5 done@17", c_done[17], e_done[17], 1);
    lit("t5 last t", last_t(1), last_t(0), 9);

    set_scn(9, 1, 0, 0, 2, 4, 150);
    stop_w[11] = 1'b1;
    run_scn("cont_stop");
    lit("t5b valid@12", c_valid[12], e_valid[12], 1);
    lit("t5b valid@13", c_valid[13], e_valid[13], 0);
    lit("t5b busy@13", c_busy[13], e_busy[13], 0);
    lit("t5b done count", count_sig(3, 1), count_sig(3, 0), 0);

    set_scn(5, 1, 3, 0, 0, 4, 12);
    rst_w[12] = 1'b1;
    run_scn("rst_wait");
    lit("t6 t@12", c_t[12], e_t[12], 1);
    lit("t6 t@13", c_t[13], e_t[13], 0);
    lit("t6 valid@13", c_valid[13], e_valid[13], 0);

    set_scn(4, 1, 0, 0, 0, 4, 60);
    for (int k = 8; k < LEN; k++) max_w[k] = 16'd1;
    run_scn("max_change");
    lit("t6b valid count", count_sig(0, 1), count_sig(0, 0), 5);
    lit("t6b last t", last_t(1), last_t(0), 4);

    set_scn(65535, 21845, 0, 0, 0, 4, 60);
    run_scn("full_range");
    lit("t7 valid count", count_sig(0, 1), count_sig(0, 0), 4);
    lit("t7 last t", last_t(1), last_t(0), 65535);

    set_scn(0, 1, 0, 2, 1, 4, 60);
    run_scn("max0");
    lit("t8 valid count", count_sig(0, 1), count_sig(0, 0), 2);
    lit("t8 sync count", count_sig(2, 1), count_sig(2, 0), 2);

    for (int i = 0; i < 24; i++) rand_scn(i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
